// File: rtl/isqrt_newton_param.sv
// isqrt_newton_param: integer square root by Newton iteration.
// Produces floor(sqrt(in)), the remainder in - out*out and the update count,
// behind a START/DONE/AVAILABLE level handshake. Seeding from the leading one
// keeps the estimate above the root, so the sequence decreases monotonically
// and stops as soon as it no longer shrinks.
module isqrt_newton_param #(
  parameter int WIDTH    = 32,
  parameter int MAX_ITER = 16,
  parameter int ITER_W   = $clog2(MAX_ITER + 1)
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic [WIDTH-1:0]    in,
  input  logic                START,
  output logic                AVAILABLE,
  output logic                DONE,
  output logic [WIDTH/2-1:0]  out,
  output logic [WIDTH/2:0]    rem,
  output logic [ITER_W-1:0]   iters,
  output logic                TIMEOUT
);

  localparam int HALF = WIDTH / 2;
  localparam int XW   = HALF + 1;
  localparam int SW   = HALF + 2;
  localparam int PW   = WIDTH + 2;
  localparam int RW   = HALF + 1;
  localparam int LW   = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    HOLD = 2'd2
  } state_t;

  logic [1:0]        rst_sync;
  logic              rst_int;
  logic              start_q;
  state_t            state, state_nx;
  logic [WIDTH-1:0]  n_r, n_nx;
  logic [XW-1:0]     x_r, x_nx;
  logic [ITER_W-1:0] cnt_r, cnt_nx;
  logic [HALF-1:0]   out_nx;
  logic [RW-1:0]     rem_nx;
  logic [ITER_W-1:0] iters_nx;
  logic              timeout_nx, avail_nx, done_nx;

  logic [LW-1:0]     bitlen;
  logic [XW-1:0]     seed;
  logic [XW-1:0]     x_div;
  logic [XW-1:0]     quot;
  logic [SW-1:0]     sum;
  logic [XW-1:0]     y;
  logic [PW-1:0]     sq;
  logic [RW-1:0]     rem_conv;
  logic [HALF-1:0]   x_sat;

  // Reset asserts immediately but releases only after two clock edges
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) rst_sync <= 2'b00;
    else       rst_sync <= {rst_sync[0], 1'b1};
  end

  assign rst_int = rst_sync[1];

  // Leading-one seed: 1 << ceil(bitlen/2) is always at or above sqrt(in)
  always_comb begin
    bitlen = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (in[i]) bitlen = LW'(i + 1);
    end
    seed = '0;
    if (bitlen != '0) seed = XW'(1) << ((bitlen + LW'(1)) >> 1);
  end

  // Newton step, remainder and saturated estimate; divisor forced nonzero so n=0 never divides by zero
  always_comb begin
    x_div    = (x_r == '0) ? XW'(1) : x_r;
    quot     = XW'(n_r / {{(WIDTH - XW){1'b0}}, x_div});
    sum      = SW'(x_r) + SW'(quot);
    y        = XW'(sum >> 1);
    sq       = PW'(x_r) * PW'(x_r);
    rem_conv = RW'(PW'(n_r) - sq);
    x_sat    = x_r[HALF] ? {HALF{1'b1}} : x_r[HALF-1:0];
  end

  // Next-state and next-output logic; START is seen through start_q in IDLE, raw in HOLD
  always_comb begin
    state_nx   = state;
    n_nx       = n_r;
    x_nx       = x_r;
    cnt_nx     = cnt_r;
    out_nx     = out;
    rem_nx     = rem;
    iters_nx   = iters;
    timeout_nx = TIMEOUT;
    avail_nx   = AVAILABLE;
    done_nx    = DONE;
    case (state)
      IDLE: begin
        avail_nx = 1'b1;
        done_nx  = 1'b0;
        if (start_q) begin
          n_nx       = in;
          x_nx       = seed;
          cnt_nx     = '0;
          avail_nx   = 1'b0;
          timeout_nx = 1'b0;
          state_nx   = ITER;
        end
      end
      ITER: begin
        if (x_r == '0 || y >= x_r) begin
          out_nx   = x_r[HALF-1:0];
          rem_nx   = rem_conv;
          iters_nx = cnt_r;
          done_nx  = 1'b1;
          state_nx = HOLD;
        end else if (cnt_r == ITER_W'(MAX_ITER)) begin
          timeout_nx = 1'b1;
          iters_nx   = cnt_r;
          rem_nx     = '0;
          out_nx     = x_sat;
          done_nx    = 1'b1;
          state_nx   = HOLD;
        end else begin
          x_nx   = y;
          cnt_nx = cnt_r + ITER_W'(1);
        end
      end
      HOLD: begin
        if (!START) begin
          done_nx  = 1'b0;
          avail_nx = 1'b1;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // State, datapath and output registers
  always_ff @(posedge clk or negedge rst_int) begin
    if (!rst_int) begin
      start_q   <= 1'b0;
      state     <= IDLE;
      n_r       <= '0;
      x_r       <= '0;
      cnt_r     <= '0;
      out       <= '0;
      rem       <= '0;
      iters     <= '0;
      TIMEOUT   <= 1'b0;
      AVAILABLE <= 1'b1;
      DONE      <= 1'b0;
    end else begin
      start_q   <= START;
      state     <= state_nx;
      n_r       <= n_nx;
      x_r       <= x_nx;
      cnt_r     <= cnt_nx;
      out       <= out_nx;
      rem       <= rem_nx;
      iters     <= iters_nx;
      TIMEOUT   <= timeout_nx;
      AVAILABLE <= avail_nx;
      DONE      <= done_nx;
    end
  end

endmodule

// File: tb/tb_isqrt_newton_param.sv
// tb_isqrt_newton_param: directed and swept checks of the Newton square root,
// with a second MAX_ITER=1 instance for the iteration cap.
module tb_isqrt_newton_param;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;

  logic [31:0] in_a = '0;
  logic        start_a = 1'b0;
  logic        avail_a, done_a, timeout_a;
  logic [15:0] out_a;
  logic [16:0] rem_a;
  logic [4:0]  iters_a;

  logic [31:0] in_b = '0;
  logic        start_b = 1'b0;
  logic        avail_b, done_b, timeout_b;
  logic [15:0] out_b;
  logic [16:0] rem_b;
  logic [0:0]  iters_b;

  int checks = 0;
  int fails  = 0;
  int cyc;

  isqrt_newton_param #(.WIDTH(32), .MAX_ITER(16)) dut (
    .clk(clk), .rstn(rstn), .in(in_a), .START(start_a),
    .AVAILABLE(avail_a), .DONE(done_a), .out(out_a), .rem(rem_a),
    .iters(iters_a), .TIMEOUT(timeout_a)
  );

  isqrt_newton_param #(.WIDTH(32), .MAX_ITER(1)) dut_cap (
    .clk(clk), .rstn(rstn), .in(in_b), .START(start_b),
    .AVAILABLE(avail_b), .DONE(done_b), .out(out_b), .rem(rem_b),
    .iters(iters_b), .TIMEOUT(timeout_b)
  );

  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches
  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
    end
  endtask

  // Bit-by-bit reference for floor(sqrt(v))
  function automatic longint sqrtModel(input longint v);
    longint r, t;
    r = 0;
    for (int b = 15; b >= 0; b--) begin
      t = r | (longint'(1) << b);
      if (t * t <= v) r = t;
    end
    return r;
  endfunction

  // Raise START with operand v and count edges after the capturing edge until DONE
  task automatic applyStimulus(input logic [31:0] v, input bit scramble, output int lat);
    @(negedge clk);
    in_a    = v;
    start_a = 1'b1;
    lat     = 0;
    @(posedge clk);
    for (int i = 0; i < 64; i++) begin
      @(posedge clk);
      #1;
      lat++;
      if (scramble && lat == 2) in_a = ~v;
      if (done_a) break;
    end
    if (!done_a) checkOutput("done_timeout", 64'd0, 64'd1);
  endtask

  // Drop START and expect the handshake to return to idle one edge later
  task automatic dropStart();
    @(negedge clk);
    start_a = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("done_fall", done_a, 1'b0);
    checkOutput("avail_rise", avail_a, 1'b1);
  endtask

  initial begin
    longint r;
    logic [31:0] v;

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_avail", avail_a, 1'b1);
    checkOutput("rst_done", done_a, 1'b0);
    checkOutput("rst_out", out_a, 0);
    checkOutput("rst_rem", rem_a, 0);
    checkOutput("rst_iters", iters_a, 0);
    checkOutput("rst_timeout", timeout_a, 1'b0);
    @(negedge clk);
    rstn = 1'b1;
    repeat (3) @(posedge clk);

    // n=16: seed 8, estimates 5,4
    applyStimulus(32'd16, 1'b0, cyc);
    checkOutput("t1_latency", cyc, 4);
    checkOutput("t1_out", out_a, 4);
    checkOutput("t1_rem", rem_a, 0);
    checkOutput("t1_iters", iters_a, 2);
    checkOutput("t1_timeout", timeout_a, 1'b0);
    checkOutput("t1_avail", avail_a, 1'b0);
    dropStart();

    // Small operands
    applyStimulus(32'd15, 1'b0, cyc);
    checkOutput("t2_15_out", out_a, 3);
    checkOutput("t2_15_rem", rem_a, 6);
    checkOutput("t2_15_iters", iters_a, 1);
    dropStart();
    applyStimulus(32'd1, 1'b0, cyc);
    checkOutput("t2_1_out", out_a, 1);
    checkOutput("t2_1_rem", rem_a, 0);
    checkOutput("t2_1_iters", iters_a, 1);
    dropStart();
    applyStimulus(32'd0, 1'b0, cyc);
    checkOutput("t2_0_latency", cyc, 2);
    checkOutput("t2_0_out", out_a, 0);
    checkOutput("t2_0_rem", rem_a, 0);
    checkOutput("t2_0_iters", iters_a, 0);
    checkOutput("t2_0_no_x", $isunknown({out_a, rem_a, iters_a, timeout_a, done_a, avail_a}), 1'b0);
    dropStart();

    // Largest operand: seed is 2^16, one update
    applyStimulus(32'hFFFF_FFFF, 1'b0, cyc);
    checkOutput("t3_out", out_a, 65535);
    checkOutput("t3_rem", rem_a, 131070);
    checkOutput("t3_iters", iters_a, 1);
    checkOutput("t3_timeout", timeout_a, 1'b0);
    dropStart();

    // Handshake hold and operand changes during ITER
    applyStimulus(32'd16, 1'b1, cyc);
    checkOutput("t5_out", out_a, 4);
    checkOutput("t5_rem", rem_a, 0);
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      checkOutput("t5_hold_done", done_a, 1'b1);
      checkOutput("t5_hold_avail", avail_a, 1'b0);
    end
    dropStart();
    checkOutput("t5_out_kept", out_a, 4);
    checkOutput("t5_iters_kept", iters_a, 2);

    // Iteration cap on the MAX_ITER=1 instance
    @(negedge clk);
    in_b    = 32'd16;
    start_b = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (done_b) break;
    end
    if (!done_b) checkOutput("t4_done_timeout", 64'd0, 64'd1);
    checkOutput("t4_timeout", timeout_b, 1'b1);
    checkOutput("t4_out", out_b, 5);
    checkOutput("t4_rem", rem_b, 0);
    checkOutput("t4_iters", iters_b, 1);
    @(negedge clk);
    start_b = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("t4_done_fall", done_b, 1'b0);

    // Reset in the middle of ITER
    @(negedge clk);
    in_a    = 32'd16;
    start_a = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    checkOutput("t6_busy", avail_a, 1'b0);
    #2;
    rstn = 1'b0;
    #1;
    checkOutput("t6_rst_avail", avail_a, 1'b1);
    checkOutput("t6_rst_done", done_a, 1'b0);
    checkOutput("t6_rst_out", out_a, 0);
    checkOutput("t6_rst_iters", iters_a, 0);
    start_a = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
    repeat (3) @(posedge clk);
    applyStimulus(32'd100, 1'b0, cyc);
    checkOutput("t6_out", out_a, 10);
    checkOutput("t6_rem", rem_a, 0);
    checkOutput("t6_iters", iters_a, 2);
    dropStart();

    // Random operands across all magnitudes against the reference
    for (int k = 0; k < 1500; k++) begin
      v = $urandom >> $urandom_range(0, 31);
      applyStimulus(v, 1'b0, cyc);
      r = sqrtModel(longint'(v));
      checkOutput("rand_out", out_a, r);
      checkOutput("rand_rem", rem_a, longint'(v) - r * r);
      checkOutput("rand_timeout", timeout_a, 1'b0);
      dropStart();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
